// File: rtl/multicore_system_dpram_ctrl.sv
// True dual-port word RAM with two Avalon-MM slave ports, read-first semantics and a post-reset clear sequencer.
// Optional per-lane even parity storage and sticky error flags when DPRAM_PARITY_EN is defined.
module multicore_system_dpram_ctrl #(
    parameter int DATA_W         = 32,
    parameter int BYTE_W         = 8,
    parameter int DEPTH          = 4096,
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       reset_req,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W/BYTE_W-1:0]   byteenable,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       clken,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic                       waitrequest,
    input  logic [ADDR_W-1:0]          address2,
    input  logic [DATA_W/BYTE_W-1:0]   byteenable2,
    input  logic                       chipselect2,
    input  logic                       write2,
    input  logic [DATA_W-1:0]          writedata2,
    input  logic                       clken2,
    output logic [DATA_W-1:0]          readdata2,
    output logic                       readdatavalid2,
`ifdef DPRAM_PARITY_EN
    output logic                       parity_err,
    output logic                       parity_err2,
`endif
    output logic                       waitrequest2
);

    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DPRAM_PARITY_EN
    localparam int MEM_W = DATA_W + BE_W;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [MEM_W-1:0]  r_mem [0:DEPTH-1];
    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic [DATA_W-1:0] r_rdata1, r_rdata2;
    logic              r_rdv1, r_rdv2;

    logic              w_acc1, w_acc2, w_wr1, w_wr2, w_rd1, w_rd2;
    logic              w_inr1, w_inr2, w_clr_we, w_busy;
    logic [IDX_W-1:0]  w_idx1, w_idx2;

    assign w_busy      = (r_state != ST_READY);
    assign waitrequest  = w_busy | reset_req;
    assign waitrequest2 = w_busy | reset_req;

    assign w_acc1 = chipselect  & clken  & ~waitrequest;
    assign w_acc2 = chipselect2 & clken2 & ~waitrequest2;
    assign w_wr1  = w_acc1 &  write;
    assign w_rd1  = w_acc1 & ~write;
    assign w_wr2  = w_acc2 &  write2;
    assign w_rd2  = w_acc2 & ~write2;

    assign w_inr1 = (32'(address)  < 32'(DEPTH));
    assign w_inr2 = (32'(address2) < 32'(DEPTH));
    assign w_idx1 = address[IDX_W-1:0];
    assign w_idx2 = address2[IDX_W-1:0];

    assign w_clr_we = reset_n & (r_state == ST_CLEAR);

    // Clear sequencer: one word per cycle; reset_req deliberately does not pause it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_IDX) begin
                r_state <= ST_READY;
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [BE_W-1:0] w_wpar1, w_wpar2;

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_wpar
            assign w_wpar1[gi] = ^writedata[gi*BYTE_W +: BYTE_W];
            assign w_wpar2[gi] = ^writedata2[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    function automatic logic f_par_bad(input logic [MEM_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < BE_W; b++) begin
            bad = bad | ((^word[b*BYTE_W +: BYTE_W]) != word[DATA_W+b]);
        end
        return bad;
    endfunction
`endif

    // s2 lanes are written before s1 lanes so s1 wins any shared lane on a same-address collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_wr2 && w_inr2 && byteenable2[b]) begin
                    r_mem[w_idx2][b*BYTE_W +: BYTE_W] <= writedata2[b*BYTE_W +: BYTE_W];
`ifdef DPRAM_PARITY_EN
                    r_mem[w_idx2][DATA_W+b] <= w_wpar2[b];
`endif
                end
                if (w_wr1 && w_inr1 && byteenable[b]) begin
                    r_mem[w_idx1][b*BYTE_W +: BYTE_W] <= writedata[b*BYTE_W +: BYTE_W];
`ifdef DPRAM_PARITY_EN
                    r_mem[w_idx1][DATA_W+b] <= w_wpar1[b];
`endif
                end
            end
        end
    end

    // Registered read ports; reads see the array before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_rdv1   <= 1'b0;
            r_rdv2   <= 1'b0;
        end else begin
            r_rdv1 <= w_rd1;
            r_rdv2 <= w_rd2;
            if (w_rd1) begin
                r_rdata1 <= w_inr1 ? r_mem[w_idx1][DATA_W-1:0] : '0;
            end
            if (w_rd2) begin
                r_rdata2 <= w_inr2 ? r_mem[w_idx2][DATA_W-1:0] : '0;
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic r_perr1, r_perr2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_perr1 <= 1'b0;
            r_perr2 <= 1'b0;
        end else begin
            if (w_rd1 && w_inr1 && f_par_bad(r_mem[w_idx1])) begin
                r_perr1 <= 1'b1;
            end
            if (w_rd2 && w_inr2 && f_par_bad(r_mem[w_idx2])) begin
                r_perr2 <= 1'b1;
            end
        end
    end

    assign parity_err  = r_perr1;
    assign parity_err2 = r_perr2;
`endif

    assign readdata       = r_rdata1;
    assign readdata2      = r_rdata2;
    assign readdatavalid  = r_rdv1;
    assign readdatavalid2 = r_rdv2;

endmodule

// File: tb/tb_multicore_system_dpram_ctrl.sv
// Self-checking bench for multicore_system_dpram_ctrl with DEPTH=16 and a 5-bit address (upper half out of range).
module tb_multicore_system_dpram_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n, reset_req;
    logic [AW-1:0] address, address2;
    logic [3:0]  byteenable, byteenable2;
    logic        chipselect, chipselect2, write, write2, clken, clken2;
    logic [31:0] writedata, writedata2, readdata, readdata2;
    logic        readdatavalid, readdatavalid2, waitrequest, waitrequest2;
`ifdef DPRAM_PARITY_EN
    logic        perr1, perr2;
`endif

    always #5 clk = ~clk;

    multicore_system_dpram_ctrl #(
        .DATA_W(32), .BYTE_W(8), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .clken(clken),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .write2(write2), .writedata2(writedata2), .clken2(clken2),
        .readdata2(readdata2), .readdatavalid2(readdatavalid2),
`ifdef DPRAM_PARITY_EN
        .parity_err(perr1), .parity_err2(perr2),
`endif
        .waitrequest2(waitrequest2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    typedef struct {
        logic        port;
        logic        wr;
        logic [AW-1:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: every readdatavalid must match the oldest expected read, including its cycle.
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL s1_unexpected_rdv: got readdata 0x%08h with no read outstanding", readdata);
            end else begin
                e1 = q1.pop_front();
                chk("s1_rdata", readdata, e1.d);
                chk("s1_latency", cyc, e1.c);
                $display("s1 read  data=0x%08h cyc=%0d", readdata, cyc);
            end
        end
        if (readdatavalid2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL s2_unexpected_rdv: got readdata2 0x%08h with no read outstanding", readdata2);
            end else begin
                e2 = q2.pop_front();
                chk("s2_rdata", readdata2, e2.d);
                chk("s2_latency", cyc, e2.c);
                $display("s2 read  data=0x%08h cyc=%0d", readdata2, cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        chipselect  = 1'b0; write  = 1'b0; byteenable  = 4'h0; writedata  = '0; address  = '0;
        chipselect2 = 1'b0; write2 = 1'b0; byteenable2 = 4'h0; writedata2 = '0; address2 = '0;
    endtask

    task automatic drv(input logic port, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        e.d = exp;
        e.c = cyc + 1;
        if (!port) begin
            chipselect = 1'b1; write = wr; address = a; byteenable = be; writedata = d;
            if (!wr) q1.push_back(e);
        end else begin
            chipselect2 = 1'b1; write2 = wr; address2 = a; byteenable2 = be; writedata2 = d;
            if (!wr) q2.push_back(e);
        end
        $display("drive  port=s%0d %s addr=%0d be=%h data=0x%08h", port ? 2 : 1, wr ? "WR" : "RD", a, be, d);
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (waitrequest && n < 100);
        chk(name, n, 16);
        chk({name, "_wait2"}, waitrequest2, 1'b0);
    endtask

    logic [AW-1:0] sa[6];
    logic [31:0]   sd[6];
    exp_t          es;

    initial begin
        tbl.push_back('{1'b0, 1'b1, 5'd3,  4'hF, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 5'd3,  4'h1, 32'h000000AA, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 5'd3,  4'hF, 32'h0,        32'hDEADBEAA});
        tbl.push_back('{1'b1, 1'b0, 5'd3,  4'hF, 32'h0,        32'hDEADBEAA});
        tbl.push_back('{1'b0, 1'b1, 5'd4,  4'hA, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd4,  4'hF, 32'h0,        32'hCA00F000});
        tbl.push_back('{1'b1, 1'b1, 5'd4,  4'h0, 32'hFFFFFFFF, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 5'd20, 4'hF, 32'h55555555, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 5'd4,  4'hF, 32'h0,        32'hCA00F000});
        tbl.push_back('{1'b0, 1'b0, 5'd20, 4'hF, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 1'b1, 5'd15, 4'hF, 32'h89ABCDEF, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd0,  4'hF, 32'h0,        32'h0});
        tbl.push_back('{1'b0, 1'b0, 5'd15, 4'hF, 32'h0,        32'h89ABCDEF});

        reset_n = 1'b0; reset_req = 1'b0; clken = 1'b1; clken2 = 1'b1;
        idle();
        repeat (3) tick();
        chk("rst_waitrequest",   waitrequest,   1'b1);
        chk("rst_waitrequest2",  waitrequest2,  1'b1);
        chk("rst_readdatavalid", readdatavalid, 1'b0);
        chk("rst_readdata2",     readdata2,     32'h0);
        reset_n = 1'b1;
        count_clear("clear_cycles");

        // Whole array after clear, both ports streaming, plus out-of-range reads.
        for (int a = 0; a < DEPTH; a++) begin
            drv(1'b0, 1'b0, AW'(a), 4'hF, 32'h0, 32'h0);
            drv(1'b1, 1'b0, AW'(DEPTH - 1 - a), 4'hF, 32'h0, 32'h0);
            tick();
            idle();
        end
        drv(1'b0, 1'b0, 5'd16, 4'hF, 32'h0, 32'h0);
        drv(1'b1, 1'b0, 5'd31, 4'hF, 32'h0, 32'h0);
        tick();
        idle();

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data, tbl[i].exp);
            tick();
            idle();
        end
        tick();
        chk("s1_hold_data", readdata, 32'h89ABCDEF);
        chk("s1_hold_rdv",  readdatavalid, 1'b0);

        // Same-address write collision: s1 owns shared lane 1.
        drv(1'b0, 1'b1, 5'd5, 4'b0011, 32'h11111111, 32'h0);
        drv(1'b1, 1'b1, 5'd5, 4'b0110, 32'h22222222, 32'h0);
        tick(); idle();
        drv(1'b0, 1'b0, 5'd5, 4'hF, 32'h0, 32'h00221111);
        tick(); idle();

        // Read-during-write from the other port returns the old word.
        drv(1'b0, 1'b1, 5'd7, 4'hF, 32'h12345678, 32'h0);
        drv(1'b1, 1'b0, 5'd7, 4'hF, 32'h0, 32'h0);
        tick(); idle();
        drv(1'b1, 1'b0, 5'd7, 4'hF, 32'h0, 32'h12345678);
        tick(); idle();

        // s1 stalled by clken for two cycles while s2 streams.
        sa[0] = 5'd3;  sd[0] = 32'hDEADBEAA;
        sa[1] = 5'd4;  sd[1] = 32'hCA00F000;
        sa[2] = 5'd5;  sd[2] = 32'h00221111;
        sa[3] = 5'd7;  sd[3] = 32'h12345678;
        sa[4] = 5'd15; sd[4] = 32'h89ABCDEF;
        sa[5] = 5'd3;  sd[5] = 32'hDEADBEAA;
        for (int i = 0; i < 6; i++) begin
            clken = !(i == 2 || i == 3);
            chipselect = 1'b1; write = 1'b0; address = sa[i]; byteenable = 4'hF;
            if (clken) begin
                es.d = sd[i];
                es.c = cyc + 1;
                q1.push_back(es);
            end
            drv(1'b1, 1'b0, sa[5-i], 4'hF, 32'h0, sd[5-i]);
            tick();
            chk("s2_stream_rdv", readdatavalid2, 1'b1);
            if (i == 2 || i == 3) chk("s1_stall_rdv", readdatavalid, 1'b0);
            idle();
        end
        clken = 1'b1;
        tick();

        // reset_req freezes both ports: read and write are refused.
        reset_req = 1'b1;
        chipselect  = 1'b1; write  = 1'b0; address  = 5'd3;
        chipselect2 = 1'b1; write2 = 1'b1; address2 = 5'd3; byteenable2 = 4'hF; writedata2 = 32'h0;
        #1;
        chk("rreq_waitrequest",  waitrequest,  1'b1);
        chk("rreq_waitrequest2", waitrequest2, 1'b1);
        tick(); idle();
        reset_req = 1'b0;
        tick();
        chk("rreq_no_rdv", readdatavalid, 1'b0);
        drv(1'b0, 1'b0, 5'd3, 4'hF, 32'h0, 32'hDEADBEAA);
        tick(); idle();
        tick();

        // Reset during clear restarts it from word 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        reset_n = 1'b0;
        tick();
        chk("midclr_waitrequest", waitrequest, 1'b1);
        reset_n = 1'b1;
        count_clear("clear_restart_cycles");
        drv(1'b0, 1'b0, 5'd3, 4'hF, 32'h0, 32'h0);
        drv(1'b1, 1'b0, 5'd15, 4'hF, 32'h0, 32'h0);
        tick(); idle();
        tick(); tick();

        chk("s1_queue_drained", 32'(q1.size()), 32'h0);
        chk("s2_queue_drained", 32'(q2.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicore_system_dpram_ctrl.md
Name: multicore_system_dpram_ctrl

Overview:
- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), per-core code/data memory in the Nios multicore system.
- Successor to the fixed 4096x32 dual-port ROM/RAM.
- Adds generic width/depth, registered reads with readdatavalid, waitrequest and a post-reset hardware clear sequencer.
- Adds deterministic same-address write-collision and read-during-write rules.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per byteenable lane; BE_W = DATA_W/BYTE_W.
- DEPTH, 4096, number of words, 2..65536.
- ADDR_W, 12, word address width; must be >= clog2(DEPTH). Addresses >= DEPTH are ignored on write and read back 0.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip clearing and go ready immediately.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- reset_req  in  1  high = freeze both ports; no new accepts, outputs hold.
- address  in  ADDR_W  s1 word address.
- byteenable  in  BE_W  s1 byte lanes.
- chipselect  in  1  s1 request.
- write  in  1  s1 write (1) / read (0).
- writedata  in  DATA_W  s1 write data.
- clken  in  1  s1 clock enable; low = s1 stalled.
- readdata  out  DATA_W  s1 read data, registered.
- readdatavalid  out  1  s1 read data valid strobe.
- waitrequest  out  1  s1 not accepting.
- address2, byteenable2, chipselect2, write2, writedata2, clken2, readdata2, readdatavalid2, waitrequest2: s2 equivalents, same widths.

Behaviour:
- Accept condition, port p: chipselect_p & clken_p & ~waitrequest_p.
- waitrequest_p = (state != READY) | reset_req. It is combinational from registered state plus reset_req.
- FSM states: CLEAR, READY.
  - reset_n low: state <= CLEAR if CLEAR_ON_RESET, else READY; clear counter <= 0.
  - CLEAR: write zero to word[clr_cnt] each cycle, clr_cnt++.
  - clr_cnt == DEPTH-1: that word is written, then state <= READY.
  - reset_req high in CLEAR does not pause clearing.
  - Clear takes exactly DEPTH cycles after reset release.
  - Re-asserting reset_n mid-clear restarts clearing at word 0.
- Reset values:
  - readdata, readdata2 = 0; readdatavalid, readdatavalid2 = 0.
  - waitrequest, waitrequest2 = 1 when CLEAR_ON_RESET=1, else 0 (while reset_req low).
  - Array contents are not reset, except through the clear sequence.
- Write: accepted write updates only the enabled byte lanes at the next rising edge. byteenable all-zero = no change.
- Read:
  - Accepted read at edge N: readdata_p valid and readdatavalid_p = 1 for one cycle after edge N (latency 1).
  - readdata_p holds its last value otherwise; readdatavalid_p = 0 otherwise.
- Back-to-back: one accept per port per cycle. Full throughput of 1 access per cycle per port, both ports concurrently.
- Write collision, both ports write the same address in the same cycle:
  - Per byte lane, s1 wins where both enable the lane.
  - Lanes enabled by only one port take that port's data.
- Read-during-write, same or other port, same address, same cycle: read returns OLD data (read-first).
- clken_p low: port p accepts nothing. readdata_p holds; readdatavalid_p = 0 from the next cycle. The other port is unaffected.
- Address out of range (>= DEPTH): write dropped, read returns 0 with readdatavalid.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte lane; the clear sequence writes correct parity for zero.
  - On each read, recomputed parity is compared per lane.
  - Any mismatch sets sticky outputs parity_err / parity_err2 (1 bit each), in the same cycle as readdatavalid.
  - Flags clear only on reset_n low.
- Not defined:
  - No parity storage; parity_err ports are absent.
  - Array width is exactly DATA_W.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1, release reset_n -> waitrequest high exactly 16 cycles, then low; read all 16 addresses on s1 -> all 0x00000000, readdatavalid one cycle after each accept.
- s1 write addr 3 = 0xDEADBEEF be=4'b1111, then s2 write addr 3 = 0x000000AA be=4'b0001, then s1 read addr 3 -> 0xDEADBEAA, latency 1.
- Same cycle: s1 write addr 5 = 0x11111111 be=4'b0011, s2 write addr 5 = 0x22222222 be=4'b0110 -> read addr 5 = 0x00221111 (from cleared 0).
- Addr 7 holds 0x0; same cycle s1 writes addr 7 = 0x12345678 and s2 reads addr 7 -> readdata2 = 0x00000000; next s2 read -> 0x12345678.
- s1 issues reads every cycle with clken pulsed low for 2 cycles -> no accepts and readdatavalid=0 during stall; s2 streaming reads continue at 1/cycle.
- Assert reset_n low at clear count 8, release -> clear restarts, waitrequest high a further 16 cycles. With DPRAM_PARITY_EN, force a flipped stored bit at addr 2, read -> parity_err=1 and stays 1 until reset.
